cdb_arbiter: RTL and testbench

- Collects result packets (`cdb_t`) from the execute-stage functional units: add, mul, div, br and mem.
- Buffers each source in a small per-source FIFO and grants one packet per cycle onto the single registered common data bus.
- The bus feeds the ROB, reservation stations and physical regfile.
- Provides per-source back-pressure, round-robin fairness and a global flush for branch recovery.

---
 rtl/rv32i_types.sv | 22 ++
 rtl/cdb_fifo.sv | 66 ++++++
 rtl/cdb_arbiter.sv | 106 ++++++++++
 tb/tb_cdb_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I out-of-order core types: common data bus packet and CDB source indices.
package rv32i_types;

  typedef struct packed {
    logic        valid;
    logic [5:0]  rob_idx;
    logic [5:0]  pd_s;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic [31:0] inst;
    logic        pc_select;
    logic [31:0] pc_branch;
  } cdb_t;

  localparam int unsigned N_CDB_SRC   = 5;
  localparam int unsigned CDB_SRC_ADD = 0;
  localparam int unsigned CDB_SRC_MUL = 1;
  localparam int unsigned CDB_SRC_DIV = 2;
  localparam int unsigned CDB_SRC_BR  = 3;
  localparam int unsigned CDB_SRC_MEM = 4;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result buffer feeding the CDB arbiter: circular buffer with a separate count.
module cdb_fifo
  import rv32i_types::*;
#(
  parameter int unsigned  DEPTH = 2,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  cdb_t          din,
  input  logic          pop,
  output cdb_t          dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  cdb_t          mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~flush & ~full;
  assign do_pop  = pop & ~flush & ~empty;

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers FU results per source and broadcasts one packet per cycle
// on a registered bus, round-robin across sources, with a global mispredict flush.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned  N_SRC = N_CDB_SRC,
  parameter int unsigned  DEPTH = 2,
  localparam int unsigned SW    = $clog2(N_SRC),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  cdb_t [N_SRC-1:0]            src_cdb,
  output logic [N_SRC-1:0]            src_ready,
  input  logic                        flush,
  output cdb_t                        cdb_out,
  output logic [SW-1:0]               grant_src,
  output logic [N_SRC-1:0][CW-1:0]    occupancy
);

  cdb_t [N_SRC-1:0] head;
  logic [N_SRC-1:0] empty;
  logic [N_SRC-1:0] full;
  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] pop;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] req_rot;
  logic [SW-1:0]    rr_ptr;
  logic [SW-1:0]    rot_idx;
  logic [SW-1:0]    gnt_idx;
  logic [SW-1:0]    rr_next;
  logic             gnt_any;
  cdb_t             gnt_pkt;

  // (a + b) mod N_SRC for operands already below N_SRC.
  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (SW + 1)'(N_SRC)) begin
      sum = sum - (SW + 1)'(N_SRC);
    end
    return sum[SW-1:0];
  endfunction

  assign src_ready = ~full;
  assign req       = ~empty;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign push[i] = src_cdb[i].valid & src_ready[i] & ~flush;
    assign pop[i]  = gnt_any & (gnt_idx == SW'(i)) & ~flush;

    cdb_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[i]),
      .din   (src_cdb[i]),
      .pop   (pop[i]),
      .dout  (head[i]),
      .empty (empty[i]),
      .full  (full[i]),
      .count (occupancy[i])
    );
  end

  // Rotate so rr_ptr sits at bit 0, pick the lowest set bit, then rotate the index back.
  always_comb begin
    req_rot = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      req_rot[i] = req[wrap_add(rr_ptr, SW'(i))];
    end

    gnt_any = 1'b0;
    rot_idx = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        gnt_any = 1'b1;
        rot_idx = SW'(i);
      end
    end

    gnt_idx       = wrap_add(rr_ptr, rot_idx);
    rr_next       = wrap_add(gnt_idx, SW'(1));
    gnt_pkt       = head[gnt_idx];
    gnt_pkt.valid = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_out   <= '0;
      grant_src <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      cdb_out <= '0;
    end else if (gnt_any) begin
      cdb_out   <= gnt_pkt;
      grant_src <= gnt_idx;
      rr_ptr    <= rr_next;
    end else begin
      cdb_out <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin order, back-pressure, flush, wrap.
module tb_cdb_arbiter;
  import rv32i_types::*;

  logic           clk;
  logic           rst;
  logic           flush;
  cdb_t [4:0]     src_cdb;
  logic [4:0]     src_ready;
  cdb_t           cdb_out;
  logic [2:0]     grant_src;
  logic [4:0][1:0] occupancy;

  int checks = 0;
  int errors = 0;
  int a_n;
  int m_n;
  cdb_t p;

  cdb_arbiter #(
    .N_SRC (5),
    .DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_cdb   (src_cdb),
    .src_ready (src_ready),
    .flush     (flush),
    .cdb_out   (cdb_out),
    .grant_src (grant_src),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  function automatic cdb_t mk(input logic [5:0] rob);
    cdb_t q;
    q           = '0;
    q.valid     = 1'b1;
    q.rob_idx   = rob;
    q.pd_s      = rob + 6'd32;
    q.rd_s      = rob[4:0];
    q.rd_v      = {26'h2AAAAAA, rob};
    q.inst      = {14'h0, rob, 12'h013};
    q.pc_branch = {24'h100, 2'b00, rob};
    return q;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    flush   = 1'b0;
    src_cdb = '0;
    #1;
    chk("rst_valid", 128'(cdb_out.valid), 128'(1'b0));
    chk("rst_cdb", 128'(cdb_out), 128'(0));
    chk("rst_ready", 128'(src_ready), 128'(5'b11111));
    chk("rst_occ", 128'(occupancy), 128'(0));
    chk("rst_grant", 128'(grant_src), 128'(0));
    tick();
    rst = 1'b1;

    // Single add packet: enqueued at edge 0, on the bus after edge 1 only.
    p            = mk(6'd3);
    p.pd_s       = 6'd40;
    p.rd_v       = 32'hDEADBEEF;
    src_cdb[0]   = p;
    tick();
    src_cdb = '0;
    chk("single_occ0", 128'(occupancy), 128'(10'd1));
    chk("single_nobypass", 128'(cdb_out.valid), 128'(1'b0));
    tick();
    chk("single_pkt", 128'(cdb_out), 128'(p));
    chk("single_grant", 128'(grant_src), 128'(0));
    chk("single_occ1", 128'(occupancy), 128'(0));
    tick();
    chk("single_gone", 128'(cdb_out), 128'(0));
    chk("single_grant_hold", 128'(grant_src), 128'(0));

    // All five collide; a second burst arrives while the first drains.
    do_reset();
    for (int i = 0; i < 5; i++) src_cdb[i] = mk(6'(i + 1));
    tick();
    for (int i = 0; i < 5; i++) src_cdb[i] = mk(6'(i + 6));
    chk("coll_occ", 128'(occupancy), 128'({5{2'd1}}));
    chk("coll_ready0", 128'(src_ready), 128'(5'b11111));
    tick();
    src_cdb = '0;
    chk("coll_pkt1", 128'(cdb_out), 128'(mk(6'd1)));
    chk("coll_grant1", 128'(grant_src), 128'(0));
    chk("coll_ready1", 128'(src_ready), 128'(5'b00001));
    for (int k = 2; k <= 10; k++) begin
      tick();
      chk($sformatf("coll_pkt%0d", k), 128'(cdb_out), 128'(mk(6'(k))));
      chk($sformatf("coll_grant%0d", k), 128'(grant_src), 128'((k - 1) % 5));
    end
    tick();
    chk("coll_idle", 128'(cdb_out.valid), 128'(1'b0));
    chk("coll_occ_end", 128'(occupancy), 128'(0));

    // Add and mul both stream whenever allowed: grants alternate, readiness alternates.
    do_reset();
    a_n = 0;
    m_n = 0;
    for (int k = 0; k <= 8; k++) begin
      src_cdb = '0;
      if (k <= 2 || k % 2 == 0) begin
        src_cdb[0] = mk(6'(20 + a_n));
        a_n++;
      end
      if (k <= 1 || k % 2 == 1) begin
        src_cdb[1] = mk(6'(40 + m_n));
        m_n++;
      end
      tick();
      chk($sformatf("bp_ready%0d", k), 128'(src_ready),
          128'((k == 0) ? 5'b11111 : ((k % 2 == 1) ? 5'b11101 : 5'b11110)));
      if (k >= 1) begin
        chk($sformatf("bp_pkt%0d", k), 128'(cdb_out),
            128'((k % 2 == 1) ? mk(6'(20 + (k - 1) / 2)) : mk(6'(40 + (k - 2) / 2))));
        chk($sformatf("bp_grant%0d", k), 128'(grant_src), 128'((k % 2 == 1) ? 0 : 1));
      end
    end
    src_cdb = '0;
    for (int k = 9; k <= 11; k++) begin
      tick();
      chk($sformatf("bp_pkt%0d", k), 128'(cdb_out),
          128'((k % 2 == 1) ? mk(6'(20 + (k - 1) / 2)) : mk(6'(40 + (k - 2) / 2))));
    end
    tick();
    chk("bp_idle", 128'(cdb_out.valid), 128'(1'b0));
    chk("bp_occ_end", 128'(occupancy), 128'(0));

    // Flush with four buffered packets (one a taken branch) and a new add input.
    do_reset();
    src_cdb[0] = mk(6'd1);
    src_cdb[1] = mk(6'd2);
    p            = mk(6'd3);
    p.pc_select  = 1'b1;
    src_cdb[3]   = p;
    src_cdb[4]   = mk(6'd4);
    tick();
    src_cdb    = '0;
    src_cdb[2] = mk(6'd5);
    tick();
    chk("fl_pre_pkt", 128'(cdb_out), 128'(mk(6'd1)));
    chk("fl_pre_occ", 128'(occupancy), 128'({2'd1, 2'd1, 2'd1, 2'd1, 2'd0}));
    src_cdb    = '0;
    src_cdb[0] = mk(6'd9);
    flush      = 1'b1;
    tick();
    flush   = 1'b0;
    src_cdb = '0;
    chk("fl_cdb", 128'(cdb_out), 128'(0));
    chk("fl_occ", 128'(occupancy), 128'(0));
    chk("fl_ready", 128'(src_ready), 128'(5'b11111));
    chk("fl_grant_hold", 128'(grant_src), 128'(0));
    tick();
    chk("fl_no_late_add", 128'(cdb_out), 128'(0));
    src_cdb[0] = mk(6'd30);
    src_cdb[1] = mk(6'd31);
    tick();
    src_cdb = '0;
    chk("fl_post_idle", 128'(cdb_out), 128'(0));
    tick();
    chk("fl_rr_hold_pkt", 128'(cdb_out), 128'(mk(6'd31)));
    chk("fl_rr_hold_grant", 128'(grant_src), 128'(1));
    tick();
    chk("fl_rr_next_pkt", 128'(cdb_out), 128'(mk(6'd30)));
    chk("fl_rr_next_grant", 128'(grant_src), 128'(0));

    // Mem streams nine packets alone: full rate, pointers wrap, never more than one buffered.
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      src_cdb[4] = mk(6'(10 + k));
      tick();
      chk($sformatf("wrap_occ%0d", k), 128'(occupancy), 128'({2'd1, 8'd0}));
      if (k >= 1) begin
        chk($sformatf("wrap_pkt%0d", k), 128'(cdb_out), 128'(mk(6'(9 + k))));
        chk($sformatf("wrap_grant%0d", k), 128'(grant_src), 128'(4));
      end
    end
    src_cdb = '0;
    tick();
    chk("wrap_last", 128'(cdb_out), 128'(mk(6'd18)));
    chk("wrap_occ_end", 128'(occupancy), 128'(0));

    // Reset arriving mid-operation discards buffered packets at once.
    do_reset();
    src_cdb[0] = mk(6'd1);
    src_cdb[1] = mk(6'd2);
    tick();
    src_cdb[0] = mk(6'd3);
    src_cdb[1] = mk(6'd4);
    tick();
    src_cdb = '0;
    chk("mid_occ", 128'(occupancy), 128'({2'd0, 2'd0, 2'd0, 2'd2, 2'd1}));
    chk("mid_pkt", 128'(cdb_out), 128'(mk(6'd1)));
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_occ", 128'(occupancy), 128'(0));
    chk("mid_rst_cdb", 128'(cdb_out), 128'(0));
    chk("mid_rst_grant", 128'(grant_src), 128'(0));
    chk("mid_rst_ready", 128'(src_ready), 128'(5'b11111));
    #1;
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
